// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-to-RAM arbiter: RAM status codes and arbiter states.
package mem_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter_arb_grant.sv
// Grant selection between icache and dcache with a bounded icache starvation counter.
module mem_arbiter_arb_grant
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned STARVE_W   = $clog2(STARVE_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dreq,
    input  logic                ireq,
    input  logic                iserv,
    input  logic                idone,
    output arbstate_t           grant_c,
    output logic [STARVE_W-1:0] starve
);

    logic starved;

    // A completing icache access clears the counter, so it no longer counts as starved.
    assign starved = (starve >= STARVE_W'(STARVE_MAX)) && !idone;

    always_comb begin
        grant_c = IDLE;
        if (dreq && !(ireq && starved)) begin
            grant_c = DSERV;
        end else if (ireq) begin
            grant_c = ISERV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (idone || !ireq) begin
            starve <= '0;
        end else if (!iserv && (starve < STARVE_W'(STARVE_MAX))) begin
            starve <= starve + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache word requests onto one RAM port, with block-transfer lock and access counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic              cctrans,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [CNT_W-1:0]  icnt,
    output logic [CNT_W-1:0]  dcnt,
    output logic [CNT_W-1:0]  errcnt
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    arbstate_t             state;
    arbstate_t             next_state;
    arbstate_t             grant;
    ramstate_t             rs;
    logic                  dreq;
    logic                  d_done;
    logic                  i_done;
    logic                  ram_err;
    logic [STARVE_W-1:0]   starve;

    assign rs      = ramstate_t'(ramstate);
    assign dreq    = dREN | dWEN;
    assign d_done  = (state == DSERV) && dreq && (rs == ACCESS);
    assign i_done  = (state == ISERV) && iREN && (rs == ACCESS);
    assign ram_err = (rs == ERROR) && (((state == DSERV) && dreq) || ((state == ISERV) && iREN));

    mem_arbiter_arb_grant #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_grant (
        .clk     (CLK),
        .rst     (RST),
        .dreq    (dreq),
        .ireq    (iREN),
        .iserv   (state == ISERV),
        .idone   (i_done),
        .grant_c (grant),
        .starve  (starve)
    );

    // Next state: the block-transfer lock keeps the dcache granted between words.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = grant;
            DSERV: begin
                if (d_done) begin
                    next_state = cctrans ? DSERV : grant;
                end else if (!cctrans && !dreq) begin
                    next_state = IDLE;
                end
            end
            ISERV: begin
                if (i_done) begin
                    next_state = grant;
                end else if (!iREN) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // RAM mux and cache handshakes follow the current owner; write wins over read.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state)
            DSERV: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dwait    = ~d_done;
            end
            ISERV: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = ramload;
                iwait   = ~i_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            icnt   <= '0;
            dcnt   <= '0;
            errcnt <= '0;
        end else begin
            state <= next_state;
            if (i_done) begin
                icnt <= icnt + CNT_W'(1);
            end
            if (d_done) begin
                dcnt <= dcnt + CNT_W'(1);
            end
            if (ram_err) begin
                errcnt <= errcnt + CNT_W'(1);
            end
        end
    end

endmodule
